// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
//
// Merges PS/2 keyboard events and per-player joystick bits into per-player
// arcade controls. Directions can be rotated for vertical monitors, coins are
// shaped into fixed-length pulses, and fire can optionally autofire.
//
// Ports
//   clk_sys      system clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   ps2_key      [10] event toggle, [9] pressed, [8:0] scan code (bit8 = extended)
//   joy_in       16 bits per player: 0 right, 1 left, 2 down, 3 up, 4 fire,
//                5 start, 6 coin (bits 15:7 unused)
//   rotate       0 none, 1 clockwise, 2 counter-clockwise, 3 180 degrees
//   autofire_en  per-player autofire enable
//   ctrl_out     5 bits per player {fire, up, down, left, right}
//   start_out    per-player start
//   coin_out     per-player shaped coin pulse
// -----------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int NPLAYERS   = 2,
    parameter int COIN_PULSE = 16,
    parameter int COIN_GAP   = 16,
    parameter int AF_PERIOD  = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic [16*NPLAYERS-1:0]  joy_in,
    input  logic [1:0]              rotate,
    input  logic [NPLAYERS-1:0]     autofire_en,
    output logic [5*NPLAYERS-1:0]   ctrl_out,
    output logic [NPLAYERS-1:0]     start_out,
    output logic [NPLAYERS-1:0]     coin_out
);

    // Bit positions inside the 7-bit raw per-player vector (same as joy_in)
    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_FIRE  = 4;
    localparam int B_START = 5;
    localparam int B_COIN  = 6;

    localparam int COIN_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNTW     = $clog2(COIN_MAX + 1);
    localparam int AFW      = $clog2(2 * AF_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_REL = 2'd3
    } coin_state_e;

    // Which raw bits of a player a scan code drives. Arrow keys of player 1
    // ignore the extended bit; everything else must match all 9 bits.
    function automatic logic [6:0] key_mask(input int player, input logic [8:0] code);
        key_mask = '0;
        if (player == 0) begin
            case (code[7:0])
                8'h75:   key_mask[B_UP]    = 1'b1;
                8'h72:   key_mask[B_DOWN]  = 1'b1;
                8'h6B:   key_mask[B_LEFT]  = 1'b1;
                8'h74:   key_mask[B_RIGHT] = 1'b1;
                default: ;
            endcase
            case (code)
                9'h029, 9'h014: key_mask[B_FIRE]  = 1'b1;
                9'h005, 9'h016: key_mask[B_START] = 1'b1;
                9'h02E:         key_mask[B_COIN]  = 1'b1;
                default: ;
            endcase
        end else if (player == 1) begin
            case (code)
                9'h02D:         key_mask[B_UP]    = 1'b1;
                9'h02B:         key_mask[B_DOWN]  = 1'b1;
                9'h023:         key_mask[B_LEFT]  = 1'b1;
                9'h034:         key_mask[B_RIGHT] = 1'b1;
                9'h01C:         key_mask[B_FIRE]  = 1'b1;
                9'h006, 9'h01E: key_mask[B_START] = 1'b1;
                9'h036:         key_mask[B_COIN]  = 1'b1;
                default: ;
            endcase
        end
    endfunction

    // The toggle copy is loaded during reset too, so the first cycle after
    // reset never sees a phantom event.
    logic toggle_reg;
    logic key_event;

    assign key_event = ps2_key[10] ^ toggle_reg;

    always_ff @(posedge clk_sys) begin
        toggle_reg <= ps2_key[10];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPLAYERS; gi++) begin : g_player
            logic [6:0]     kb_reg;
            logic [6:0]     mask;
            logic [6:0]     raw;
            logic           unused_joy_bits;
            logic           up_rot, down_rot, left_rot, right_rot;
            logic [3:0]     dir_next;
            logic [3:0]     dir_reg;
            logic           fire_next, fire_reg, start_reg;
            logic [AFW-1:0] af_cnt_reg, af_cnt_next;
            coin_state_e    coin_state_reg, coin_state_next;
            logic [CNTW-1:0] coin_cnt_reg, coin_cnt_next;
            logic           coin_prev_reg;

            assign mask            = key_mask(gi, ps2_key[8:0]);
            assign raw             = kb_reg | joy_in[16*gi +: 7];
            assign unused_joy_bits = ^joy_in[16*gi+7 +: 9];

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    kb_reg <= '0;
                end else if (key_event) begin
                    kb_reg <= ps2_key[9] ? (kb_reg | mask) : (kb_reg & ~mask);
                end
            end

            // Each output direction takes the raw direction that rotation
            // brings into its place.
            always_comb begin
                up_rot    = raw[B_UP];
                down_rot  = raw[B_DOWN];
                left_rot  = raw[B_LEFT];
                right_rot = raw[B_RIGHT];
                case (rotate)
                    2'd1: begin
                        up_rot    = raw[B_LEFT];
                        down_rot  = raw[B_RIGHT];
                        left_rot  = raw[B_DOWN];
                        right_rot = raw[B_UP];
                    end
                    2'd2: begin
                        up_rot    = raw[B_RIGHT];
                        down_rot  = raw[B_LEFT];
                        left_rot  = raw[B_UP];
                        right_rot = raw[B_DOWN];
                    end
                    2'd3: begin
                        up_rot    = raw[B_DOWN];
                        down_rot  = raw[B_UP];
                        left_rot  = raw[B_RIGHT];
                        right_rot = raw[B_LEFT];
                    end
                    default: ;
                endcase
            end

            // Opposing directions cancel each other out.
            assign dir_next = {up_rot & ~down_rot, down_rot & ~up_rot,
                               left_rot & ~right_rot, right_rot & ~left_rot};

            // af_cnt_reg counts held output cycles modulo 2*AF_PERIOD; the
            // first half of each period is high.
            always_comb begin
                af_cnt_next = '0;
                fire_next   = raw[B_FIRE];
                if (autofire_en[gi]) begin
                    fire_next = 1'b0;
                    if (raw[B_FIRE]) begin
                        fire_next   = (af_cnt_reg < AFW'(AF_PERIOD));
                        af_cnt_next = (af_cnt_reg == AFW'(2 * AF_PERIOD - 1)) ?
                                      '0 : af_cnt_reg + AFW'(1);
                    end
                end
            end

            always_comb begin
                coin_state_next = coin_state_reg;
                coin_cnt_next   = coin_cnt_reg;
                case (coin_state_reg)
                    ST_IDLE: begin
                        if (raw[B_COIN] && !coin_prev_reg) begin
                            coin_state_next = ST_PULSE;
                            coin_cnt_next   = '0;
                        end
                    end
                    ST_PULSE: begin
                        if (coin_cnt_reg == CNTW'(COIN_PULSE - 1)) begin
                            coin_state_next = ST_GAP;
                            coin_cnt_next   = '0;
                        end else begin
                            coin_cnt_next = coin_cnt_reg + CNTW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (coin_cnt_reg == CNTW'(COIN_GAP - 1)) begin
                            coin_state_next = raw[B_COIN] ? ST_WAIT_REL : ST_IDLE;
                            coin_cnt_next   = '0;
                        end else begin
                            coin_cnt_next = coin_cnt_reg + CNTW'(1);
                        end
                    end
                    ST_WAIT_REL: begin
                        if (!raw[B_COIN]) begin
                            coin_state_next = ST_IDLE;
                        end
                    end
                    default: coin_state_next = ST_IDLE;
                endcase
            end

            // coin_prev_reg follows the raw coin during reset as well, so a
            // coin already held at reset release needs a release first.
            always_ff @(posedge clk_sys) begin
                coin_prev_reg <= raw[B_COIN];
                if (reset) begin
                    dir_reg        <= '0;
                    fire_reg       <= 1'b0;
                    start_reg      <= 1'b0;
                    af_cnt_reg     <= '0;
                    coin_state_reg <= ST_IDLE;
                    coin_cnt_reg   <= '0;
                end else begin
                    dir_reg        <= dir_next;
                    fire_reg       <= fire_next;
                    start_reg      <= raw[B_START];
                    af_cnt_reg     <= af_cnt_next;
                    coin_state_reg <= coin_state_next;
                    coin_cnt_reg   <= coin_cnt_next;
                end
            end

            assign ctrl_out[5*gi +: 5] = {fire_reg, dir_reg};
            assign start_out[gi]       = start_reg;
            assign coin_out[gi]        = (coin_state_reg == ST_PULSE);
        end
    endgenerate

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;
    localparam int NP = 2;
    localparam int CP = 16;
    localparam int CG = 16;
    localparam int AF = 8;

    logic             clk_sys = 1'b0;
    logic             reset = 1'b1;
    logic [10:0]      ps2_key = '0;
    logic [16*NP-1:0] joy_in = '0;
    logic [1:0]       rotate = '0;
    logic [NP-1:0]    autofire_en = '0;
    logic [5*NP-1:0]  ctrl_out;
    logic [NP-1:0]    start_out;
    logic [NP-1:0]    coin_out;

    arcade_input_mapper #(
        .NPLAYERS(NP), .COIN_PULSE(CP), .COIN_GAP(CG), .AF_PERIOD(AF)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
        .rotate(rotate), .autofire_en(autofire_en), .ctrl_out(ctrl_out),
        .start_out(start_out), .coin_out(coin_out)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [6:0]      m_kb [NP] = '{default: '0};
    bit              m_tog = 1'b0;
    bit              m_prev [NP];
    int              m_busy [NP];
    int              m_hold [NP];
    bit              m_valid = 1'b0;
    logic [5*NP-1:0] e_ctrl = '0;
    logic [NP-1:0]   e_start = '0;
    logic [NP-1:0]   e_coin = '0;
    logic [6:0]      m_r;
    logic [3:0]      m_d;
    logic            m_f;

    // Raw-bit mask a scan code sets for player p, straight from the key table.
    function automatic logic [6:0] kmap(input int p, input logic [8:0] c);
        logic [6:0] m;
        m = '0;
        if (p == 0) begin
            if (c[7:0] == 8'h75) m[3] = 1'b1;
            if (c[7:0] == 8'h72) m[2] = 1'b1;
            if (c[7:0] == 8'h6B) m[1] = 1'b1;
            if (c[7:0] == 8'h74) m[0] = 1'b1;
            if (c == 9'h029 || c == 9'h014) m[4] = 1'b1;
            if (c == 9'h005 || c == 9'h016) m[5] = 1'b1;
            if (c == 9'h02E) m[6] = 1'b1;
        end else if (p == 1) begin
            if (c == 9'h02D) m[3] = 1'b1;
            if (c == 9'h02B) m[2] = 1'b1;
            if (c == 9'h023) m[1] = 1'b1;
            if (c == 9'h034) m[0] = 1'b1;
            if (c == 9'h01C) m[4] = 1'b1;
            if (c == 9'h006 || c == 9'h01E) m[5] = 1'b1;
            if (c == 9'h036) m[6] = 1'b1;
        end
        return m;
    endfunction

    // Directions on a compass (0 up, 1 right, 2 down, 3 left); a clockwise
    // turn makes output d take compass point d-1, counter-clockwise d+1.
    function automatic logic [3:0] rot(input logic [6:0] r, input logic [1:0] rt);
        logic [3:0] cmp, o;
        int k;
        cmp = {r[1], r[2], r[0], r[3]};
        k = (rt == 2'd1) ? 3 : (rt == 2'd2) ? 1 : (rt == 2'd3) ? 2 : 0;
        for (int d = 0; d < 4; d++) o[d] = cmp[(d + k) % 4];
        if (o[0] && o[2]) begin o[0] = 1'b0; o[2] = 1'b0; end
        if (o[1] && o[3]) begin o[1] = 1'b0; o[3] = 1'b0; end
        return {o[0], o[2], o[3], o[1]};
    endfunction

    always @(posedge clk_sys) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_r = m_kb[p] | joy_in[16*p +: 7];
                m_prev[p] = m_r[6];
                m_kb[p] = '0;
                m_busy[p] = 0;
                m_hold[p] = 0;
            end
            e_ctrl = '0;
            e_start = '0;
            e_coin = '0;
            m_tog = ps2_key[10];
            m_valid = 1'b1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                m_r = m_kb[p] | joy_in[16*p +: 7];
                m_d = rot(m_r, rotate);
                if (autofire_en[p] && m_r[4]) begin
                    m_hold[p]++;
                    m_f = ((m_hold[p] - 1) % (2 * AF)) < AF;
                end else begin
                    m_hold[p] = 0;
                    m_f = m_r[4] && !autofire_en[p];
                end
                // A pulse opens a window of CP high + CG low cycles that
                // swallows further coin edges.
                if (m_busy[p] > 0) m_busy[p]--;
                else if (m_r[6] && !m_prev[p]) m_busy[p] = CP + CG;
                m_prev[p] = m_r[6];
                e_ctrl[5*p +: 5] = {m_f, m_d};
                e_start[p] = m_r[5];
                e_coin[p] = (m_busy[p] > CG);
            end
            if (ps2_key[10] != m_tog) begin
                for (int p = 0; p < NP; p++) begin
                    if (ps2_key[9]) m_kb[p] = m_kb[p] | kmap(p, ps2_key[8:0]);
                    else m_kb[p] = m_kb[p] & ~kmap(p, ps2_key[8:0]);
                end
            end
            m_tog = ps2_key[10];
        end
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            check("model_ctrl", 32'(ctrl_out), 32'(e_ctrl));
            check("model_start", 32'(start_out), 32'(e_start));
            check("model_coin", 32'(coin_out), 32'(e_coin));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    logic [8:0] codes [22] = '{9'h175, 9'h075, 9'h072, 9'h16B, 9'h074, 9'h029, 9'h014,
                               9'h005, 9'h016, 9'h02E, 9'h02D, 9'h02B, 9'h023, 9'h034,
                               9'h01C, 9'h006, 9'h01E, 9'h036, 9'h11C, 9'h0AA, 9'h12E,
                               9'h136};

    initial begin
        int highs, rises, bad;
        bit last;

        reset = 1'b1;
        tick(3);
        check("reset_ctrl", 32'(ctrl_out), 0);
        check("reset_start", 32'(start_out), 0);
        check("reset_coin", 32'(coin_out), 0);
        reset = 1'b0;
        tick(1);
        check("idle_ctrl", 32'(ctrl_out), 0);

        // keyboard up: visible two edges after the event
        key(1'b1, 9'h175);
        tick(1);
        check("key_up_edge_n", 32'(ctrl_out[3]), 0);
        tick(1);
        check("key_up_edge_n1", 32'(ctrl_out[3]), 1);
        key(1'b0, 9'h175);
        tick(2);
        check("key_up_release", 32'(ctrl_out[3]), 0);

        // rotation and opposing cancel
        rotate = 2'd1;
        joy_in[1] = 1'b1;
        tick(1);
        check("cw_left_to_up", 32'(ctrl_out[3:0]), 32'b1000);
        rotate = 2'd0;
        joy_in[0] = 1'b1;
        tick(1);
        check("left_right_cancel", 32'(ctrl_out[3:0]), 0);
        joy_in = '0;
        tick(2);

        // coin held ~100 cycles with a release/re-press inside the gap
        highs = 0; rises = 0; last = 1'b0;
        key(1'b1, 9'h02E);
        for (int i = 0; i < 100; i++) begin
            if (i == 20) key(1'b0, 9'h02E);
            if (i == 25) key(1'b1, 9'h02E);
            tick(1);
            if (coin_out[0]) highs++;
            if (coin_out[0] && !last) rises++;
            last = coin_out[0];
        end
        check("coin_high_cycles", 32'(highs), 16);
        check("coin_pulse_count", 32'(rises), 1);
        key(1'b0, 9'h02E);
        tick(3);
        check("coin_idle_after", 32'(coin_out), 0);

        // player 2 autofire
        autofire_en = 2'b10;
        key(1'b1, 9'h01C);
        tick(1);
        for (int i = 0; i < 36; i++) begin
            tick(1);
            check($sformatf("af_cycle_%0d", i), 32'(ctrl_out[9]), ((i % 16) < 8) ? 1 : 0);
        end
        key(1'b0, 9'h01C);
        tick(1);
        check("af_release_edge", 32'(ctrl_out[9]), 1);
        tick(1);
        check("af_after_release", 32'(ctrl_out[9]), 0);
        autofire_en = '0;
        tick(2);

        // reset in the middle of a coin pulse with a key latched
        key(1'b1, 9'h175);
        tick(2);
        check("latched_up", 32'(ctrl_out[3]), 1);
        key(1'b1, 9'h02E);
        tick(4);
        check("coin_mid_pulse", 32'(coin_out[0]), 1);
        reset = 1'b1;
        key(1'b1, 9'h175);
        tick(1);
        check("mid_reset_ctrl", 32'(ctrl_out), 0);
        check("mid_reset_coin", 32'(coin_out), 0);
        tick(1);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (ctrl_out != '0 || coin_out != '0) bad++;
        end
        check("no_spurious_after_reset", 32'(bad), 0);

        // joystick coin already held at reset release
        joy_in[6] = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (coin_out[0]) bad++;
        end
        check("held_coin_no_pulse", 32'(bad), 0);
        joy_in[6] = 1'b0;
        tick(1);
        joy_in[6] = 1'b1;
        tick(1);
        check("coin_after_repress", 32'(coin_out[0]), 1);
        joy_in[6] = 1'b0;
        tick(40);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int p;
            int b;
            p = $urandom_range(0, NP - 1);
            b = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) joy_in[16*p + b] = ~joy_in[16*p + b];
            if ($urandom_range(0, 31) == 0) joy_in[16*p+7 +: 9] = 9'($urandom);
            if ($urandom_range(0, 9) == 0) key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 21)]);
            if ($urandom_range(0, 63) == 0) rotate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) autofire_en = NP'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
